// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with a small first-word fall-through
// character FIFO. Prefix bytes (E0/F0/E1) are tracked by a 4-state FSM; left
// and right shift are tracked separately. Mapped make codes are staged for one
// cycle, then pushed. The visible head/valid outputs are registered copies of
// the FIFO state and therefore trail the push edge by one cycle.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          iCLK_50MHZ,
    input  logic                          iRST_N,
    input  logic [7:0]                    iSCAN_CODE,
    input  logic                          iSCAN_VALID,
    output logic [7:0]                    oASCII,
    output logic                          oASCII_VALID,
    input  logic                          iASCII_READ,
    output logic [$clog2(FIFO_DEPTH):0]   oFIFO_COUNT,
    output logic                          oSHIFT,
    output logic                          oOVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Returns {mapped, character} for a make code under the given shift state.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        logic       hit;
        logic       letter;
        ch     = 8'h00;
        hit    = 1'b1;
        letter = 1'b1;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            8'h45: begin ch = 8'h30; letter = 1'b0; end
            8'h16: begin ch = 8'h31; letter = 1'b0; end
            8'h1E: begin ch = 8'h32; letter = 1'b0; end
            8'h26: begin ch = 8'h33; letter = 1'b0; end
            8'h25: begin ch = 8'h34; letter = 1'b0; end
            8'h2E: begin ch = 8'h35; letter = 1'b0; end
            8'h36: begin ch = 8'h36; letter = 1'b0; end
            8'h3D: begin ch = 8'h37; letter = 1'b0; end
            8'h3E: begin ch = 8'h38; letter = 1'b0; end
            8'h46: begin ch = 8'h39; letter = 1'b0; end
            8'h29: begin ch = 8'h20; letter = 1'b0; end
            8'h5A: begin ch = 8'h0D; letter = 1'b0; end
            8'h66: begin ch = 8'h08; letter = 1'b0; end
            default: begin hit = 1'b0; letter = 1'b0; end
        endcase
        if (letter && shift) begin
            ch = ch - 8'h20;
        end else begin
            ch = ch;
        end
        return {hit, ch};
    endfunction

    state_t          state_q, state_d;
    logic            shift_l_q, shift_l_d;
    logic            shift_r_q, shift_r_d;
    logic            pend_q, pend_d;
    logic [7:0]      pend_char_q, pend_char_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [7:0]      ascii_q, ascii_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            make_s;
    logic            brk_s;
    logic [8:0]      map_s;
    logic            pop_s;
    logic            full_s;
    logic            push_s;
    logic            drop_s;

    // Prefix FSM, shift tracking and make-code staging.
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        map_s       = map_code(iSCAN_CODE, shift_l_q | shift_r_q);
        if (iSCAN_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    if (iSCAN_CODE == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (iSCAN_CODE == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (iSCAN_CODE == 8'hE1) begin
                        state_d = ST_IDLE;
                    end else begin
                        make_s  = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (iSCAN_CODE == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_s   = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        if ((make_s || brk_s) && iSCAN_CODE == 8'h12) begin
            shift_l_d = make_s;
        end else begin
            shift_l_d = shift_l_d;
        end
        if ((make_s || brk_s) && iSCAN_CODE == 8'h59) begin
            shift_r_d = make_s;
        end else begin
            shift_r_d = shift_r_d;
        end
        pend_d      = make_s & map_s[8];
        pend_char_d = map_s[7:0];
    end

    // FIFO pointer/count bookkeeping and registered head view.
    always_comb begin
        pop_s    = iASCII_READ && (count_q != {CW{1'b0}});
        full_s   = (count_q == CW'(FIFO_DEPTH));
        push_s   = pend_q && (!full_s || pop_s);
        drop_s   = pend_q && full_s && !pop_s;
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d    = ovf_q | drop_s;
        valid_d  = (count_q != {CW{1'b0}});
        if (valid_d) begin
            ascii_d = mem_q[rd_ptr_q];
        end else begin
            ascii_d = 8'h00;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_char_q <= 8'h00;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            ascii_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            pend_q      <= pend_d;
            pend_char_q <= pend_char_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            ascii_q     <= ascii_d;
        end
    end

    // Character storage; contents are don't-care until written.
    always_ff @(posedge iCLK_50MHZ) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= pend_char_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign oASCII       = ascii_q;
    assign oASCII_VALID = valid_q;
    assign oFIFO_COUNT  = count_q;
    assign oSHIFT       = shift_l_q | shift_r_q;
    assign oOVERFLOW    = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios followed by a
// randomized code/pop stream compared against a queue-based reference model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic                      clk;
    logic                      rst_n;
    logic [7:0]                scan_code;
    logic                      scan_valid;
    logic [7:0]                ascii;
    logic                      ascii_valid;
    logic                      ascii_read;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      shift;
    logic                      overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    byte unsigned m_q[$];
    bit  m_ext, m_brk, m_shl, m_shr, m_ovf;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .iCLK_50MHZ  (clk),
        .iRST_N      (rst_n),
        .iSCAN_CODE  (scan_code),
        .iSCAN_VALID (scan_valid),
        .oASCII      (ascii),
        .oASCII_VALID(ascii_valid),
        .iASCII_READ (ascii_read),
        .oFIFO_COUNT (fifo_count),
        .oSHIFT      (shift),
        .oOVERFLOW   (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Character for a make code, or -1 when the code produces nothing.
    function automatic int ref_map(input byte unsigned code, input bit sh);
        byte unsigned letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        byte unsigned digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                      8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++)
            if (letters[i] == code) return (sh ? 65 : 97) + i;
        for (int i = 0; i < 10; i++)
            if (digits[i] == code) return 48 + i;
        if (code == 8'h29) return 32;
        if (code == 8'h5A) return 13;
        if (code == 8'h66) return 8;
        return -1;
    endfunction

    // Model one received byte, optionally with a pop on the push cycle.
    task automatic model_code(input byte unsigned code, input bit rd);
        int ch;
        ch = -1;
        if (!m_ext && !m_brk) begin
            if (code == 8'hE0) m_ext = 1;
            else if (code == 8'hF0) m_brk = 1;
            else if (code != 8'hE1) begin
                ch = ref_map(code, m_shl | m_shr);
                if (code == 8'h12) m_shl = 1;
                if (code == 8'h59) m_shr = 1;
            end
        end else if (m_ext && !m_brk) begin
            if (code == 8'hF0) m_brk = 1;
            else m_ext = 0;
        end else if (!m_ext && m_brk) begin
            if (code == 8'h12) m_shl = 0;
            if (code == 8'h59) m_shr = 0;
            m_brk = 0;
        end else begin
            m_ext = 0;
            m_brk = 0;
        end
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (ch >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(byte'(ch));
            else m_ovf = 1;
        end
    endtask

    // Send one byte; returns at the falling edge just after the push edge.
    task automatic send(input byte unsigned code, input bit rd);
        @(negedge clk);
        scan_code  = code;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        ascii_read = rd;
        @(negedge clk);
        ascii_read = 1'b0;
        model_code(code, rd);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        ascii_read = 1'b1;
        @(negedge clk);
        ascii_read = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
        settle();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
        chk({tag, ".valid"}, 32'(ascii_valid), 32'(m_q.size() != 0));
        chk({tag, ".ascii"}, 32'(ascii), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk({tag, ".shift"}, 32'(shift), 32'(m_shl | m_shr));
        chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst.count", 32'(fifo_count), 32'h0);
        chk("rst.valid", 32'(ascii_valid), 32'h0);
        chk("rst.ascii", 32'(ascii), 32'h0);
        chk("rst.shift", 32'(shift), 32'h0);
        chk("rst.ovf",   32'(overflow), 32'h0);
        m_q.delete();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        byte unsigned pool[] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h1C, 8'h32,
                                 8'h1A, 8'h4D, 8'h45, 8'h46, 8'h29, 8'h5A, 8'h66,
                                 8'h0E, 8'h75, 8'h76, 8'h16};
        rst_n      = 1'b1;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        ascii_read = 1'b0;
        @(negedge clk);
        do_reset();

        // Single make/break with latency check.
        send(8'h1C, 1'b0);
        chk("lat.count1", 32'(fifo_count), 32'h1);
        chk("lat.valid_early", 32'(ascii_valid), 32'h0);
        @(negedge clk);
        chk("lat.valid", 32'(ascii_valid), 32'h1);
        chk("lat.ascii", 32'(ascii), 32'h61);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0); settle();
        check_all("a_mk_brk");
        chk("a.count", 32'(fifo_count), 32'h1);

        // Shifted letter then unshifted.
        do_reset();
        send(8'h12, 1'b0); settle();
        chk("sh.on", 32'(shift), 32'h1);
        send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h12, 1'b0); settle();
        chk("sh.off", 32'(shift), 32'h0);
        send(8'h32, 1'b0); settle();
        chk("sh.head", 32'(ascii), 32'h41);
        check_all("sh");
        pop();
        chk("sh.second", 32'(ascii), 32'h62);
        check_all("sh.pop");

        // Extended codes are ignored and the FSM returns to IDLE.
        do_reset();
        send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'hE0, 1'b0);
        send(8'hF0, 1'b0); send(8'h75, 1'b0); send(8'h0E, 1'b0); settle();
        chk("ext.count", 32'(fifo_count), 32'h0);
        send(8'h1C, 1'b0); settle();
        chk("ext.idle", 32'(ascii), 32'h61);

        // Overflow: five pushes into a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h16, 1'b0);
        settle();
        chk("ovf.count", 32'(fifo_count), 32'h4);
        chk("ovf.flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf.pop", 32'(ascii), 32'h31);
            pop();
        end
        chk("ovf.empty", 32'(fifo_count), 32'h0);
        chk("ovf.ascii0", 32'(ascii), 32'h0);
        pop();
        chk("ovf.underflow", 32'(fifo_count), 32'h0);
        chk("ovf.sticky", 32'(overflow), 32'h1);

        // Push and pop in the same cycle while full.
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h16, 1'b0);
        send(8'h45, 1'b1); settle();
        chk("pp.count", 32'(fifo_count), 32'h4);
        chk("pp.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("pp.pop", 32'(ascii), (i == 3) ? 32'h30 : 32'h31);
            pop();
        end

        // Reset in the middle of a prefix.
        send(8'hE0, 1'b0);
        do_reset();
        send(8'h29, 1'b0); settle();
        chk("rstpfx.ascii", 32'(ascii), 32'h20);
        check_all("rstpfx");

        // Randomized codes and pops against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pop();
            end else begin
                send(pool[$urandom_range(0, pool.size() - 1)], $urandom_range(0, 3) == 0);
                settle();
            end
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
